bcd_stopwatch: RTL and testbench

//   8-digit BCD stopwatch core, format HH:MM:SS.cc, run/stop/clear control.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/bcd_stopwatch_digit.sv | 44 ++++
 rtl/bcd_stopwatch.sv | 165 ++++++++++++++++
 tb/tb_bcd_stopwatch.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stopwatch_pkg
//  Description : Shared types and constants for the BCD stopwatch.
//                FSM state encoding, per-digit modulus table and BCD width.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  // Control FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 8;

  // Modulus per display position, rightmost (hundredths units) first:
  // cc units, cc tens, SS units, SS tens, MM units, MM tens, HH units, HH tens
  localparam int DIG_MOD [NUM_DIGITS] = '{10, 10, 10, 6, 10, 6, 10, 10};

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_stopwatch_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One modulo-MOD BCD counter digit of the stopwatch cascade.
//  Ports       : clk    in   system clock
//                reset  in   synchronous active-high reset
//                clr    in   synchronous clear to zero
//                inc    in   advance by one this cycle
//                q      out  current digit value (0..MOD-1)
//                carry  out  inc while at MOD-1 (feeds next digit's inc)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] C_MAX = BCD_W'(MOD - 1);

  logic at_max;

  // Treat anything at or above the top as the top so the digit can never
  // wander outside its modulus.
  assign at_max = (q >= C_MAX);
  assign carry  = inc && at_max;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + BCD_W'(1);
    end
  end

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch
//  Description : 8-digit BCD stopwatch core, HH:MM:SS.cc, run/stop/clear.
//                Optional lap hold built when macro STOPWATCH_LAP_EN is
//                defined; otherwise lap is ignored and lap_hold is 0.
//  Ports       : clk         in   system clock
//                reset       in   synchronous active-high reset
//                start_stop  in   pulse, toggles run/stop
//                clear       in   pulse, zero the count while stopped
//                lap         in   pulse, toggle lap hold (lap build only)
//                digits      out  8 BCD nibbles, [3:0] = cc units
//                running     out  high while counting
//                tick        out  strobe on each count advance
//                wrap        out  strobe when 99:59:59.99 rolls to zero
//                lap_hold    out  high while display shows the snapshot
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_stop,
  input  logic                          clear,
  input  logic                          lap,
  output logic [NUM_DIGITS*BCD_W-1:0]   digits,
  output logic                          running,
  output logic                          tick,
  output logic                          wrap,
  output logic                          lap_hold
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] C_PRE_MAX = PW'(TICK_DIV - 1);

  state_t                        state_q;
  state_t                        state_d;
  logic                          presc_clr;
  logic                          digit_clr;
  logic [PW-1:0]                 presc;
  logic [NUM_DIGITS-1:0]         inc_chain;
  logic [NUM_DIGITS-1:0]         carry;
  logic [NUM_DIGITS*BCD_W-1:0]   live;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_clr = 1'b0;
    digit_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop) begin
          state_d   = RUN;
          presc_clr = 1'b1;
        end
      end
      RUN: begin
        // clear has no effect while counting
        if (start_stop) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // clear takes priority over a simultaneous start_stop
        if (clear) begin
          state_d   = IDLE;
          presc_clr = 1'b1;
          digit_clr = 1'b1;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        presc_clr = 1'b1;
        digit_clr = 1'b1;
      end
    endcase
  end

  assign running = (state_q == RUN);

  // --------------------------------------------------------------------------
  // Prescaler: advances only while running, holds its value while stopped
  // --------------------------------------------------------------------------
  assign tick = running && (presc == C_PRE_MAX);

  always_ff @(posedge clk) begin
    if (reset || presc_clr) begin
      presc <= '0;
    end else if (running) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Digit cascade: each digit increments on the carry of the one below
  // --------------------------------------------------------------------------
  assign inc_chain = {carry[NUM_DIGITS-2:0], tick};

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit #(
      .MOD (DIG_MOD[k])
    ) u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (digit_clr),
      .inc   (inc_chain[k]),
      .q     (live[k*BCD_W +: BCD_W]),
      .carry (carry[k])
    );
  end : g_digit

  // Top-digit carry already implies every digit is at max; the tick term
  // keeps the strobe confined to genuine count advances.
  assign wrap = tick && carry[NUM_DIGITS-1];

  // --------------------------------------------------------------------------
  // Lap hold
  // --------------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
  logic                        hold_q;
  logic [NUM_DIGITS*BCD_W-1:0] snap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else if (state_d == IDLE) begin
      hold_q <= 1'b0;
    end else if (lap && running) begin
      hold_q <= !hold_q;
      if (!hold_q) begin
        snap_q <= live;
      end
    end
  end

  assign lap_hold = hold_q;
  assign digits   = hold_q ? snap_q : live;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign lap_hold   = 1'b0;
  assign digits     = live;
`endif

endmodule : bcd_stopwatch
`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_stopwatch
//  Description : Directed self-checking bench for bcd_stopwatch with
//                CLK_HZ=100, TICK_HZ=10 (ten clocks per count).
//                Lap checks adapt to macro STOPWATCH_LAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [31:0] digits;
  logic        running;
  logic        tick;
  logic        wrap;
  logic        lap_hold;

  int total = 0;
  int bad   = 0;

  bcd_stopwatch #(
    .CLK_HZ  (100),
    .TICK_HZ (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .digits     (digits),
    .running    (running),
    .tick       (tick),
    .wrap       (wrap),
    .lap_hold   (lap_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs and samples sit 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    step(2);
    reset = 1'b0;
    check("rst_digits", digits, 32'h0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_lap_hold", 32'(lap_hold), 32'd0);

    // ---------------- first tick latency ----------------
    pulse_ss();                        // RUN, prescaler 0
    check("run_running", 32'(running), 32'd1);
    step(8);                           // prescaler 8
    check("pre_tick_low", 32'(tick), 32'd0);
    step(1);                           // prescaler 9
    check("tick10_high", 32'(tick), 32'd1);
    check("tick10_digits", digits, 32'h0);
    step(1);
    check("first_count", digits, 32'h0000_0001);
    check("tick_one_cycle", 32'(tick), 32'd0);

    // ---------------- hundredths carry into seconds ----------------
    step(980);
    check("count_99", digits, 32'h0000_0099);
    step(10);
    check("count_1s", digits, 32'h0000_0100);

    // ---------------- stop mid-prescale, resume ----------------
    step(4);                           // prescaler 4
    pulse_ss();                        // STOP, prescaler held at 5
    check("stop_running", 32'(running), 32'd0);
    step(20);
    check("stop_hold", digits, 32'h0000_0100);
    check("stop_no_tick", 32'(tick), 32'd0);
    pulse_ss();                        // RUN, prescaler 5
    step(3);
    check("resume_tick_low", 32'(tick), 32'd0);
    step(1);
    check("resume_tick_high", 32'(tick), 32'd1);
    step(1);
    check("resume_count", digits, 32'h0000_0101);

    // ---------------- clear behaviour ----------------
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_in_run_running", 32'(running), 32'd1);
    check("clr_in_run_digits", digits, 32'h0000_0101);
    pulse_ss();                        // STOP
    clear = 1'b1;
    start_stop = 1'b1;
    step(1);
    clear = 1'b0;
    start_stop = 1'b0;
    check("clr_ss_running", 32'(running), 32'd0);
    check("clr_ss_digits", digits, 32'h0);
    step(15);
    check("idle_stays_zero", digits, 32'h0);

    // ---------------- wrap at 99:59:59.99 ----------------
    pulse_ss();                        // RUN, prescaler 0
    pulse_ss();                        // STOP, prescaler 1
    force dut.inc_chain = 8'hFF;       // every digit +5
    step(5);
    force dut.inc_chain = 8'hD7;       // mod-10 digits +4 more
    step(4);
    release dut.inc_chain;
    check("preload", digits, 32'h9959_5999);
    pulse_ss();                        // RUN, prescaler 1
    step(7);
    check("pre_wrap_low", 32'(wrap), 32'd0);
    step(1);                           // prescaler 9
    check("wrap_high", 32'(wrap), 32'd1);
    step(1);
    check("wrap_digits", digits, 32'h0);
    check("wrap_one_cycle", 32'(wrap), 32'd0);
    check("wrap_running", 32'(running), 32'd1);
    step(10);
    check("after_wrap_count", digits, 32'h0000_0001);

    // ---------------- lap ----------------
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    pulse_ss();
    step(50);
    check("lap_pre", digits, 32'h0000_0005);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
    check("lap_hold_set", 32'(lap_hold), 32'd1);
    step(200);
    check("lap_frozen", digits, 32'h0000_0005);
`else
    check("lap_hold_off", 32'(lap_hold), 32'd0);
    step(200);
    check("lap_ignored", digits, 32'h0000_0025);
`endif
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    check("lap_release", 32'(lap_hold), 32'd0);
    check("lap_live", digits, 32'h0000_0025);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd_stopwatch
`default_nettype wire
